serial_adder: RTL and testbench

- Bit-serial WIDTH-bit adder built around a single full-adder cell and a carry flip-flop.
- Takes parallel operands and a carry-in, then adds one bit per clock, LSB first.
- Presents the parallel sum and carry-out with a start/busy/done handshake.
- Sits downstream of the gate-level full adder in the datapath; it is the sequential stage that reuses that cell across cycles.

---
 rtl/serial_adder.sv | 173 +++++++++++++++++
 tb/tb_serial_adder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder. One full-adder cell plus a carry flip-flop is
// reused across WIDTH clock cycles, LSB first. Operands are captured in
// parallel when a request is accepted. The parallel sum and carry-out are
// published together when the last bit completes.
//
// Optional feature (compile-time macro SERIAL_ADDER_OVF_EN):
//   adds a registered signed-overflow output 'ovf'. This is the carry into the
//   MSB XOR the carry out of the MSB. It updates and holds together with
//   sum/cout.
//
// Parameters:
//   WIDTH  operand/sum width in bits (2..32), default 8
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request; accepted only in IDLE or DONE
//   a      in   WIDTH  operand A, sampled on the accept edge
//   b      in   WIDTH  operand B, sampled on the accept edge
//   cin    in   1      carry-in, sampled on the accept edge
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle completion pulse
//   sum    out  WIDTH  registered result, held until the next completion
//   cout   out  1      registered carry-out, held until the next completion
//   ovf    out  1      (SERIAL_ADDER_OVF_EN only) registered signed overflow
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Counter only needs to reach WIDTH-1. WIDTH >= 2 keeps CW >= 1.
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_sr_q;
    logic [WIDTH-1:0]   b_sr_q;
    logic               carry_q;
    logic [CW-1:0]      cnt_q;
    // Working sum holds the bits produced so far. The bit produced on the
    // final edge goes straight into the result, so WIDTH-1 bits suffice.
    logic [WIDTH-2:0]   work_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               busy_q;
    logic               done_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q;
`endif

    // Full-adder cell and next-state values derived from it.
    logic               fa_s;
    logic               carry_d;
    logic [WIDTH-1:0]   sum_d;
    logic [WIDTH-2:0]   work_d;
    logic               last_bit;

    always_comb begin
        fa_s     = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        carry_d  = (a_sr_q[0] & b_sr_q[0]) | ((a_sr_q[0] ^ b_sr_q[0]) & carry_q);
        // New bit enters at the MSB. After the final bit this is the full sum.
        sum_d    = {fa_s, work_q};
        work_d   = sum_d[WIDTH-1:1];
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        work_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // start is deliberately ignored here.
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    carry_q <= carry_d;
                    work_q  <= work_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_bit) begin
                        sum_q   <= sum_d;
                        cout_q  <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry_q is the carry into the MSB at this point.
                        ovf_q   <= carry_q ^ carry_d;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    done_q <= 1'b0;
                    // Back-to-back accept: no IDLE cycle needed.
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        work_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    typedef struct packed {
        logic       cout;
        logic [7:0] sum;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a_s, b_s;
    logic       cin_s;
    logic       busy, done, cout;
    logic [7:0] sum;
    logic       ovf_obs;

    logic       start4;
    logic [3:0] a4, b4;
    logic       cin4;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int         n_vec  = 0;
    int         n_fail = 0;
    exp_t       sb[$];
    logic [4:0] q4[$];
    logic [7:0] last_sum  = 8'h00;
    logic       last_cout = 1'b0;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_w, ovf4_w;
    assign ovf_obs = ovf_w;
`else
    assign ovf_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_s), .b(b_s), .cin(cin_s),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf_w)
`endif
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf4_w)
`endif
    );

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic c);
        exp_t       e;
        logic [8:0] t;
        logic [7:0] lo;
        t      = {1'b0, a} + {1'b0, b} + {8'h00, c};
        lo     = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'h00, c};
        e.sum  = t[7:0];
        e.cout = t[8];
        e.ovf  = lo[7] ^ t[8];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is positioned on a falling edge; the next rising edge accepts.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic c);
        start = 1'b1;
        a_s   = a;
        b_s   = b;
        cin_s = c;
        sb.push_back(model(a, b, c));
        $display("launch a=%02h b=%02h cin=%0d", a, b, c);
    endtask

    // Waits for done, checking timing, output stability and the result.
    // glitch_at > 1 re-pulses start with scrambled operands mid-operation.
    task automatic wait_result(input int glitch_at);
        int   cyc      = 0;
        int   busy_cyc = 0;
        bit   seen     = 0;
        exp_t e;
        while (cyc < 40 && !seen) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (glitch_at > 1 && cyc == glitch_at) begin
                start = 1'b1;
                a_s   = 8'($urandom);
                b_s   = 8'($urandom);
                cin_s = 1'($urandom);
            end
            if (glitch_at > 1 && cyc == glitch_at + 1) start = 1'b0;
            if (busy) begin
                busy_cyc++;
                check("hold_sum", {24'h0, sum}, {24'h0, last_sum});
                check("hold_cout", {31'h0, cout}, {31'h0, last_cout});
            end
            if (done) seen = 1;
        end
        check("done_seen", {31'h0, seen}, 32'd1);
        check("latency", cyc, 32'd9);
        check("busy_cycles", busy_cyc, 32'd8);
        check("busy_done_excl", {31'h0, busy & done}, 32'd0);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("sum", {24'h0, sum}, {24'h0, e.sum});
            check("cout", {31'h0, cout}, {31'h0, e.cout});
`ifdef SERIAL_ADDER_OVF_EN
            check("ovf", {31'h0, ovf_obs}, {31'h0, e.ovf});
`endif
            $display("result sum=%02h cout=%0d ovf=%0d (exp %02h/%0d/%0d)",
                     sum, cout, ovf_obs, e.sum, e.cout, e.ovf);
            last_sum  = e.sum;
            last_cout = e.cout;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a_s = '0; b_s = '0; cin_s = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_sum", {24'h0, sum}, 32'd0);
        check("rst_cout", {31'h0, cout}, 32'd0);
        check("rst_ovf", {31'h0, ovf_obs}, 32'd0);
        rst_n = 1'b1;

        // Zero operands.
        @(negedge clk); launch(8'h00, 8'h00, 1'b0); wait_result(0);

        // Wrap to carry, then back-to-back from the done cycle.
        @(negedge clk); launch(8'hFF, 8'h01, 1'b0); wait_result(0);
        launch(8'hA5, 8'h5A, 1'b1); wait_result(0);

        // Signed overflow cases.
        @(negedge clk); launch(8'h7F, 8'h01, 1'b0); wait_result(0);
        @(negedge clk); launch(8'h80, 8'h80, 1'b0); wait_result(0);
        @(negedge clk); launch(8'h0F, 8'h10, 1'b1); wait_result(0);

        // Start re-pulsed with new operands mid-operation must be ignored.
        @(negedge clk); launch(8'h12, 8'h34, 1'b0); wait_result(3);
        @(negedge clk);
        check("done_once", {31'h0, done}, 32'd0);
        check("no_restart", {31'h0, busy}, 32'd0);

        // Asynchronous reset in the middle of an operation.
        launch(8'hFF, 8'hFF, 1'b1);
        @(negedge clk); start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_busy", {31'h0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'h0, busy}, 32'd0);
        check("arst_done", {31'h0, done}, 32'd0);
        check("arst_sum", {24'h0, sum}, 32'd0);
        check("arst_cout", {31'h0, cout}, 32'd0);
        check("arst_ovf", {31'h0, ovf_obs}, 32'd0);
        void'(sb.pop_front());
        last_sum = 8'h00; last_cout = 1'b0;
        $display("async reset applied mid-operation");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); launch(8'h03, 8'h04, 1'b0); wait_result(0);

        // Exhaustive WIDTH=4.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            logic [4:0] ex;
            bit         got;
            v = 9'(i);
            @(negedge clk);
            start4 = 1'b1; a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8];
            q4.push_back({1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'h0, v[8]});
            @(negedge clk);
            start4 = 1'b0;
            got = 0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clk);
                if (done4) got = 1;
            end
            ex = q4.pop_front();
            if (!got) check("w4_timeout", 32'd0, 32'd1);
            check("w4_result", {27'h0, cout4, sum4}, {27'h0, ex});
            $display("w4 a=%h b=%h cin=%0d -> %0d%h (exp %02h)", a4, b4, cin4, cout4, sum4, ex);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
